// File: rtl/if_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes, FSM states,
// and word-alignment helper for redirect targets.
package if_stage_pkg;

    typedef enum logic [1:0] {
        PC_SEL_FLUSH  = 2'd0,
        PC_SEL_TARGET = 2'd1,
        PC_SEL_HOLD   = 2'd2,
        PC_SEL_PLUS4  = 2'd3
    } pc_sel_e;

    localparam int PC_SEL_NUM_INPUTS = 4;

    typedef enum logic {
        IF_S_RESET = 1'b0,
        IF_S_RUN   = 1'b1
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: redirect/stall inputs from the pipeline and fetch/ID outputs.
// master = if_stage, slave = the surrounding pipeline (or a testbench).
interface if_stage_if;
    logic        mem_flush;
    logic [31:0] mem_target;
    logic        ex_target_taken;
    logic [31:0] ex_target;
    logic        id_stall;
    logic [31:0] fetch_addr;
    logic        fetch_en;
    logic        fetch_bios_sel;
    logic [31:0] id_pc;
    logic        id_squash;

    modport master (
        input  mem_flush, mem_target, ex_target_taken, ex_target, id_stall,
        output fetch_addr, fetch_en, fetch_bios_sel, id_pc, id_squash
    );

    modport slave (
        output mem_flush, mem_target, ex_target_taken, ex_target, id_stall,
        input  fetch_addr, fetch_en, fetch_bios_sel, id_pc, id_squash
    );
endinterface

// File: rtl/if_stage_pc_sel.sv
// Next-PC priority encoder: flush beats EX redirect, both beat a stall.
module if_stage_pc_sel
    import if_stage_pkg::*;
(
    input  logic    mem_flush,
    input  logic    ex_target_taken,
    input  logic    id_stall,
    output pc_sel_e sel
);

    always_comb begin
        sel = PC_SEL_PLUS4;
        if (mem_flush)            sel = PC_SEL_FLUSH;
        else if (ex_target_taken) sel = PC_SEL_TARGET;
        else if (id_stall)        sel = PC_SEL_HOLD;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and reset sequencing.
// Optional perf counters are built only when IF_PERF_CNT_EN is defined.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    if_stage_if.master           bus,
    output logic [CNT_WIDTH-1:0] perf_cycles,
    output logic [CNT_WIDTH-1:0] perf_fetched,
    output logic [CNT_WIDTH-1:0] perf_redirects
);

    if_state_e   state_q, state_d;
    pc_sel_e     sel;
    logic [31:0] pc_cand [PC_SEL_NUM_INPUTS];
    logic [31:0] next_pc;
    logic [31:0] id_pc_q;
    logic        fetch_en;
    logic        id_squash;

    if_stage_pc_sel u_pc_sel (
        .mem_flush       (bus.mem_flush),
        .ex_target_taken (bus.ex_target_taken),
        .id_stall        (bus.id_stall),
        .sel             (sel)
    );

    always_comb begin
        pc_cand[PC_SEL_FLUSH]  = word_align(bus.mem_target);
        pc_cand[PC_SEL_TARGET] = word_align(bus.ex_target);
        pc_cand[PC_SEL_HOLD]   = id_pc_q;
        pc_cand[PC_SEL_PLUS4]  = id_pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IF_S_RESET;
        else     state_q <= state_d;
    end

    // rst overrides everything combinationally so the reset cycle itself already fetches RESET_PC
    always_comb begin
        state_d   = state_q;
        next_pc   = RESET_PC;
        fetch_en  = 1'b1;
        id_squash = 1'b1;
        case (state_q)
            IF_S_RESET: state_d = IF_S_RUN;
            IF_S_RUN: begin
                next_pc   = pc_cand[sel];
                fetch_en  = (sel != PC_SEL_HOLD);
                id_squash = 1'b0;
            end
        endcase
        if (rst) begin
            state_d   = IF_S_RESET;
            next_pc   = RESET_PC;
            fetch_en  = 1'b1;
            id_squash = 1'b1;
        end
    end

    // Memory read is synchronous, so registering next_pc keeps id_pc aligned with the returned word
    always_ff @(posedge clk) begin
        if (rst) id_pc_q <= RESET_PC - 32'd4;
        else     id_pc_q <= next_pc;
    end

    assign bus.fetch_addr     = next_pc;
    assign bus.fetch_en       = fetch_en;
    assign bus.fetch_bios_sel = next_pc[30];
    assign bus.id_pc          = id_pc_q;
    assign bus.id_squash      = id_squash;

`ifdef IF_PERF_CNT_EN
    logic fetched_inc;
    logic redirect_inc;

    assign fetched_inc  = (state_q == IF_S_RUN) && !bus.id_stall &&
                          !bus.mem_flush && !bus.ex_target_taken;
    assign redirect_inc = bus.mem_flush || bus.ex_target_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles    <= '0;
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            perf_cycles <= perf_cycles + 1'b1;
            if (fetched_inc)  perf_fetched   <= perf_fetched + 1'b1;
            if (redirect_inc) perf_redirects <= perf_redirects + 1'b1;
        end
    end
`else
    assign perf_cycles    = '0;
    assign perf_fetched   = '0;
    assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver queues per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_if_stage;
    import if_stage_pkg::*;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] M_FA = 6'd1, M_FE = 6'd2, M_BS = 6'd4,
                           M_PC = 6'd8, M_SQ = 6'd16, M_PF = 6'd32;
    localparam logic [5:0] M_ALL = M_FA | M_FE | M_BS | M_PC | M_SQ;

    typedef struct {
        string       tag;
        logic [5:0]  mask;
        logic [31:0] fa;
        logic        fe;
        logic [31:0] pc;
        logic        sq;
        logic [31:0] pcyc;
        logic [31:0] pfet;
        logic [31:0] pred;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] perf_cycles, perf_fetched, perf_redirects;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb [$];

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h4000_0000), .CNT_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master),
        .perf_cycles    (perf_cycles),
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pe(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.mask[0]) chk({e.tag, ".fetch_addr"}, bus.fetch_addr, e.fa);
            if (e.mask[1]) chk({e.tag, ".fetch_en"}, 32'(bus.fetch_en), 32'(e.fe));
            if (e.mask[2]) chk({e.tag, ".bios_sel"}, 32'(bus.fetch_bios_sel), 32'(e.fa[30]));
            if (e.mask[3]) chk({e.tag, ".id_pc"}, bus.id_pc, e.pc);
            if (e.mask[4]) chk({e.tag, ".id_squash"}, 32'(bus.id_squash), 32'(e.sq));
            if (e.mask[5]) begin
                chk({e.tag, ".perf_cycles"}, perf_cycles, e.pcyc);
                chk({e.tag, ".perf_fetched"}, perf_fetched, e.pfet);
                chk({e.tag, ".perf_redirects"}, perf_redirects, e.pred);
            end
        end
    end

    task automatic drive(input logic r, input logic mf, input logic [31:0] mt,
                         input logic et_v, input logic [31:0] et, input logic st);
        rst                 = r;
        bus.mem_flush       = mf;
        bus.mem_target      = mt;
        bus.ex_target_taken = et_v;
        bus.ex_target       = et;
        bus.id_stall        = st;
    endtask

    task automatic step(input string tag, input logic [5:0] mask,
                        input logic [31:0] fa, input logic fe, input logic [31:0] pc,
                        input logic sq, input int c, input int f, input int r);
        exp_t e;
        e.tag = tag; e.mask = mask; e.fa = fa; e.fe = fe; e.pc = pc; e.sq = sq;
        e.pcyc = pe(c); e.pfet = pe(f); e.pred = pe(r);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        // reset held, then released
        step("rst0", M_ALL | M_PF, 32'h4000_0000, 1'b1, 32'h3FFF_FFFC, 1'b1, 0, 0, 0);
        step("rst1", M_ALL,        32'h4000_0000, 1'b1, 32'h3FFF_FFFC, 1'b1, 0, 0, 0);
        step("rst2", M_ALL,        32'h4000_0000, 1'b1, 32'h3FFF_FFFC, 1'b1, 0, 0, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step("rel",  M_ALL | M_PF, 32'h4000_0000, 1'b1, 32'h3FFF_FFFC, 1'b1, 0, 0, 0);
        step("run0", M_ALL,        32'h4000_0004, 1'b1, 32'h4000_0000, 1'b0, 0, 0, 0);
        step("run1", M_ALL,        32'h4000_0008, 1'b1, 32'h4000_0004, 1'b0, 0, 0, 0);
        // two stalled cycles
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step("stl0", M_ALL,        32'h4000_0008, 1'b0, 32'h4000_0008, 1'b0, 0, 0, 0);
        step("stl1", M_ALL,        32'h4000_0008, 1'b0, 32'h4000_0008, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step("unstl", M_ALL,       32'h4000_000C, 1'b1, 32'h4000_0008, 1'b0, 0, 0, 0);
        // EX redirects, the second one with misaligned target
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000_0020, 1'b0);
        step("ex0",  M_ALL,        32'h1000_0020, 1'b1, 32'h4000_000C, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000_0023, 1'b0);
        step("ex1",  M_ALL,        32'h1000_0020, 1'b1, 32'h1000_0020, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step("ex2",  M_ALL,        32'h1000_0024, 1'b1, 32'h1000_0020, 1'b0, 0, 0, 0);
        // flush + EX redirect + stall together: flush wins, fetch enabled
        drive(1'b0, 1'b1, 32'h1000_0100, 1'b1, 32'h1000_0200, 1'b1);
        step("all3", M_ALL,        32'h1000_0100, 1'b1, 32'h1000_0024, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        step("flhi", M_ALL,        32'hFFFF_FFFC, 1'b1, 32'h1000_0100, 1'b0, 0, 0, 0);
        // PC+4 wraps to zero
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step("wrap", M_ALL | M_PF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0, 11, 4, 4);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h4000_0010, 1'b1);
        step("exstl", M_ALL,       32'h4000_0010, 1'b1, 32'h0000_0000, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step("stl2", M_ALL,        32'h4000_0010, 1'b0, 32'h4000_0010, 1'b0, 0, 0, 0);
        // reset asserted while stalled
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step("rststl", M_ALL | M_PF, 32'h4000_0000, 1'b1, 32'h4000_0010, 1'b1, 14, 5, 5);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step("sreset", M_ALL | M_PF, 32'h4000_0000, 1'b1, 32'h3FFF_FFFC, 1'b1, 0, 0, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step("rerun", M_ALL | M_PF, 32'h4000_0004, 1'b1, 32'h4000_0000, 1'b0, 1, 0, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
